// File: rtl/cardinal_nic_pkg.sv
// rtl/cardinal_nic_pkg.sv - shared nic register map and sequencer state encoding
package cardinal_nic_pkg;

   localparam logic [1:0] NIC_ADDR_DATA     = 2'b00;
   localparam logic [1:0] NIC_ADDR_IN_STAT  = 2'b01;
   localparam logic [1:0] NIC_ADDR_OUT_WR   = 2'b10;
   localparam logic [1:0] NIC_ADDR_OUT_STAT = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_TX_POLL = 3'd1,
      ST_TX_CHK  = 3'd2,
      ST_TX_WR   = 3'd3,
      ST_RX_POLL = 3'd4,
      ST_RX_CHK  = 3'd5,
      ST_RX_RD   = 3'd6,
      ST_RX_CAP  = 3'd7
   } ctrl_state_t;

endpackage

// File: rtl/cardinal_nic_ctrl.sv
// rtl/cardinal_nic_ctrl.sv - PE-side sequencer turning tx/rx packet streams into nic register cycles
module cardinal_nic_ctrl
   import cardinal_nic_pkg::*;
#(
   parameter int DATA_W      = 64,
   parameter int CNT_W       = 16,
   parameter int STALL_LIMIT = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic              tx_valid,
   input  logic [DATA_W-1:0] tx_data,
   output logic              tx_ready,
   output logic              rx_valid,
   output logic [DATA_W-1:0] rx_data,
   input  logic              rx_ready,
   output logic              nic_en,
   output logic              nic_wr_en,
   output logic [1:0]        nic_addr,
   output logic [DATA_W-1:0] nic_din,
   input  logic [DATA_W-1:0] nic_dout,
   output logic              tx_stall,
   output logic [CNT_W-1:0]  tx_count,
   output logic [CNT_W-1:0]  rx_count
);

   localparam int BUSY_W = $clog2(STALL_LIMIT + 1);
   localparam logic [BUSY_W-1:0] BUSY_MAX = BUSY_W'(STALL_LIMIT);

   ctrl_state_t       state;
   logic              last_tx;
   logic [BUSY_W-1:0] busy_cnt;
   logic              tx_req;
   logic              rx_req;

   assign tx_req   = enable & tx_valid;
   // A held rx packet blocks further in-status polls, back-pressuring the nic.
   assign rx_req   = enable & ~rx_valid;
   assign tx_stall = (busy_cnt >= BUSY_MAX);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= ST_IDLE;
         last_tx  <= 1'b0;
         busy_cnt <= '0;
         rx_valid <= 1'b0;
         rx_data  <= '0;
         tx_count <= '0;
         rx_count <= '0;
      end else begin
         if (rx_valid && rx_ready)
            rx_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (tx_req && (!rx_req || !last_tx)) begin
                  state   <= ST_TX_POLL;
                  last_tx <= 1'b1;
               end else if (rx_req) begin
                  state   <= ST_RX_POLL;
                  last_tx <= 1'b0;
               end
            end
            ST_TX_POLL: state <= ST_TX_CHK;
            ST_TX_CHK: begin
               if (!nic_dout[0]) begin
                  state <= ST_TX_WR;
               end else begin
                  state <= ST_IDLE;
                  if (busy_cnt != BUSY_MAX)
                     busy_cnt <= busy_cnt + BUSY_W'(1);
               end
            end
            ST_TX_WR: begin
               tx_count <= tx_count + CNT_W'(1);
               busy_cnt <= '0;
               state    <= ST_IDLE;
            end
            ST_RX_POLL: state <= ST_RX_CHK;
            ST_RX_CHK:  state <= nic_dout[0] ? ST_RX_RD : ST_IDLE;
            ST_RX_RD:   state <= ST_RX_CAP;
            ST_RX_CAP: begin
               rx_data  <= nic_dout;
               rx_valid <= 1'b1;
               rx_count <= rx_count + CNT_W'(1);
               state    <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // nic strobes depend only on the state register, so reset silences them at once.
   always_comb begin
      nic_en    = 1'b0;
      nic_wr_en = 1'b0;
      nic_addr  = NIC_ADDR_DATA;
      nic_din   = '0;
      tx_ready  = 1'b0;
      case (state)
         ST_TX_POLL: begin
            nic_en   = 1'b1;
            nic_addr = NIC_ADDR_OUT_STAT;
         end
         ST_TX_WR: begin
            nic_en    = 1'b1;
            nic_wr_en = 1'b1;
            nic_addr  = NIC_ADDR_OUT_WR;
            nic_din   = tx_data;
            tx_ready  = 1'b1;
         end
         ST_RX_POLL: begin
            nic_en   = 1'b1;
            nic_addr = NIC_ADDR_IN_STAT;
         end
         ST_RX_RD: begin
            nic_en   = 1'b1;
            nic_addr = NIC_ADDR_DATA;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_cardinal_nic_ctrl.sv
// tb/tb_cardinal_nic_ctrl.sv - directed scoreboard bench for cardinal_nic_ctrl with a cycle-accurate nic model
module tb_cardinal_nic_ctrl;

   logic        clk;
   logic        reset;
   logic        enable;
   logic        tx_valid;
   logic [63:0] tx_data;
   logic        tx_ready;
   logic        rx_valid;
   logic [63:0] rx_data;
   logic        rx_ready;
   logic        nic_en;
   logic        nic_wr_en;
   logic [1:0]  nic_addr;
   logic [63:0] nic_din;
   logic [63:0] nic_dout;
   logic        tx_stall;
   logic [15:0] tx_count;
   logic [15:0] rx_count;

   int          checks;
   int          failures;
   logic [63:0] exp_tx[$];
   logic [63:0] exp_rx[$];
   logic [63:0] nic_rxq[$];
   int          poll_log[$];
   logic        out_busy;
   bit          tx_auto;
   int          wr_cnt;
   int          busy_polls;
   int          data_reads;
   int          wr0;

   cardinal_nic_ctrl #(.DATA_W(64), .CNT_W(16), .STALL_LIMIT(16)) dut (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .tx_valid  (tx_valid),
      .tx_data   (tx_data),
      .tx_ready  (tx_ready),
      .rx_valid  (rx_valid),
      .rx_data   (rx_data),
      .rx_ready  (rx_ready),
      .nic_en    (nic_en),
      .nic_wr_en (nic_wr_en),
      .nic_addr  (nic_addr),
      .nic_din   (nic_din),
      .nic_dout  (nic_dout),
      .tx_stall  (tx_stall),
      .tx_count  (tx_count),
      .rx_count  (rx_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge: observe this cycle, advance one clock, apply the nic's registered read data.
   task automatic tick();
      logic [63:0] pend;
      bit          took;
      pend = nic_dout;
      took = tx_ready;
      if (nic_en && !nic_wr_en) begin
         case (nic_addr)
            2'b11: begin
               pend = {63'd0, out_busy};
               poll_log.push_back(0);
               if (out_busy) busy_polls++;
            end
            2'b01: begin
               pend = {63'd0, (nic_rxq.size() != 0)};
               poll_log.push_back(1);
            end
            2'b00: begin
               data_reads++;
               pend = (nic_rxq.size() != 0) ? nic_rxq.pop_front() : 64'd0;
            end
            default: pend = 64'd0;
         endcase
      end
      if (nic_en && nic_wr_en) begin
         wr_cnt++;
         chk("wr_tx_ready", tx_ready, 1'b1);
         chk("wr_addr", nic_addr, 2'b10);
         chk("tx_sb_pending", exp_tx.size() > 0, 1'b1);
         if (exp_tx.size() > 0) chk("tx_sb_data", nic_din, exp_tx.pop_front());
      end
      if (rx_valid && rx_ready) begin
         chk("rx_sb_pending", exp_rx.size() > 0, 1'b1);
         if (exp_rx.size() > 0) chk("rx_sb_data", rx_data, exp_rx.pop_front());
      end
      @(posedge clk);
      #1;
      nic_dout = pend;
      if (took) begin
         if (tx_auto) begin
            tx_data = tx_data + 64'd1;
            exp_tx.push_back(tx_data);
         end else begin
            tx_valid = 1'b0;
         end
      end
      @(negedge clk);
   endtask

   initial begin
      checks = 0; failures = 0;
      wr_cnt = 0; busy_polls = 0; data_reads = 0;
      out_busy = 1'b0; tx_auto = 1'b0; nic_dout = '0;
      reset = 1'b0; enable = 1'b0; tx_valid = 1'b0; tx_data = '0; rx_ready = 1'b0;

      // 1: reset held with random inputs
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         enable   = 1'($urandom);
         tx_valid = 1'($urandom);
         tx_data  = {$urandom, $urandom};
         rx_ready = 1'($urandom);
      end
      @(negedge clk);
      chk("rst_nic_en", nic_en, 1'b0);
      chk("rst_nic_wr_en", nic_wr_en, 1'b0);
      chk("rst_nic_addr", nic_addr, 2'b00);
      chk("rst_nic_din", nic_din, 64'd0);
      chk("rst_tx_ready", tx_ready, 1'b0);
      chk("rst_rx_valid", rx_valid, 1'b0);
      chk("rst_rx_data", rx_data, 64'd0);
      chk("rst_tx_count", tx_count, 16'd0);
      chk("rst_rx_count", rx_count, 16'd0);
      chk("rst_tx_stall", tx_stall, 1'b0);
      enable = 1'b0; tx_valid = 1'b0; rx_ready = 1'b0; tx_data = '0;
      reset = 1'b1;
      repeat (3) tick();
      chk("idle_after_rst", nic_en, 1'b0);

      // 2: single TX with exact cycle latency
      enable = 1'b1; tx_valid = 1'b1; tx_data = 64'hA5A5_0000_0000_0001;
      exp_tx.push_back(tx_data);
      tick();
      chk("tx_c1_en", nic_en, 1'b1);
      chk("tx_c1_wr", nic_wr_en, 1'b0);
      chk("tx_c1_addr", nic_addr, 2'b11);
      tick();
      chk("tx_c2_en", nic_en, 1'b0);
      tick();
      chk("tx_c3_en", nic_en, 1'b1);
      chk("tx_c3_wr", nic_wr_en, 1'b1);
      chk("tx_c3_addr", nic_addr, 2'b10);
      chk("tx_c3_din", nic_din, 64'hA5A5_0000_0000_0001);
      chk("tx_c3_ready", tx_ready, 1'b1);
      tick();
      chk("tx_c4_ready", tx_ready, 1'b0);
      chk("tx_count_1", tx_count, 16'd1);

      // 3: out-status busy for 20 polls, stall threshold, then recovery
      out_busy = 1'b1; tx_valid = 1'b1; tx_data = 64'h0000_0000_DEAD_BEEF;
      exp_tx.push_back(tx_data);
      busy_polls = 0; wr0 = wr_cnt;
      for (int i = 0; i < 400 && busy_polls < 16; i++) tick();
      chk("busy_polls_16", busy_polls, 16);
      chk("stall_before_16th", tx_stall, 1'b0);
      tick();
      chk("stall_after_16th", tx_stall, 1'b1);
      for (int i = 0; i < 400 && busy_polls < 20; i++) tick();
      chk("busy_polls_20", busy_polls, 20);
      chk("busy_no_write", wr_cnt, wr0);
      chk("stall_held", tx_stall, 1'b1);
      out_busy = 1'b0;
      for (int i = 0; i < 40 && wr_cnt == wr0; i++) tick();
      chk("busy_then_write", wr_cnt, wr0 + 1);
      chk("stall_cleared", tx_stall, 1'b0);
      chk("tx_count_2", tx_count, 16'd2);

      // 4: RX delivery, backpressure and consume; enable=0 lets the block settle in IDLE first
      enable = 1'b0;
      repeat (6) tick();
      chk("enable0_idle", nic_en, 1'b0);
      nic_rxq.push_back(64'h8000_0000_0000_0042);
      exp_rx.push_back(64'h8000_0000_0000_0042);
      data_reads = 0; rx_ready = 1'b0; enable = 1'b1;
      tick();
      chk("rx_c1_en", nic_en, 1'b1);
      chk("rx_c1_addr", nic_addr, 2'b01);
      tick();
      tick();
      chk("rx_c3_en", nic_en, 1'b1);
      chk("rx_c3_addr", nic_addr, 2'b00);
      tick();
      chk("rx_c4_valid", rx_valid, 1'b0);
      tick();
      chk("rx_c5_valid", rx_valid, 1'b1);
      chk("rx_c5_data", rx_data, 64'h8000_0000_0000_0042);
      chk("rx_data_reads", data_reads, 1);
      poll_log.delete();
      repeat (10) tick();
      chk("rx_no_repoll", poll_log.size(), 0);
      chk("rx_data_stable", rx_data, 64'h8000_0000_0000_0042);
      chk("rx_valid_held", rx_valid, 1'b1);
      rx_ready = 1'b1;
      tick();
      rx_ready = 1'b0;
      chk("rx_valid_cleared", rx_valid, 1'b0);
      chk("rx_count_1", rx_count, 16'd1);

      // 5: fairness with tx always pending and rx side empty
      enable = 1'b0;
      repeat (6) tick();
      poll_log.delete();
      out_busy = 1'b0; tx_auto = 1'b1; tx_valid = 1'b1; tx_data = 64'h1000;
      exp_tx.push_back(tx_data);
      wr0 = wr_cnt; enable = 1'b1;
      for (int i = 0; i < 200 && poll_log.size() < 8; i++) tick();
      chk("fair_polls", poll_log.size(), 8);
      for (int i = 0; i < 8 && i < poll_log.size(); i++)
         chk($sformatf("poll_order_%0d", i), poll_log[i], i % 2);
      chk("fair_writes", wr_cnt - wr0, 4);
      chk("tx_count_6", tx_count, 16'd6);

      // 6: async reset during TX_WR
      for (int i = 0; i < 40 && !(nic_en && nic_wr_en); i++) tick();
      chk("reached_tx_wr", nic_wr_en, 1'b1);
      chk("tx_count_pre_rst", tx_count, 16'd6);
      reset = 1'b0;
      #1;
      chk("arst_nic_en", nic_en, 1'b0);
      chk("arst_tx_ready", tx_ready, 1'b0);
      chk("arst_tx_count", tx_count, 16'd0);
      tx_valid = 1'b0; tx_auto = 1'b0; enable = 1'b0;
      exp_tx.delete();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      repeat (3) tick();
      chk("post_arst_count", tx_count, 16'd0);
      chk("post_arst_idle", nic_en, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
